// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the fetch/data AXI4-Lite bus arbiter: FSM states and requester ids.
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrReq,
    StWrResp
  } state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way grant logic (fetch vs data) with fixed-priority or round-robin selection.
module mem_bus_arbiter_rr_arb2
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ArbMode = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_if_i,
  input  logic req_d_i,
  input  logic en_i,
  output logic gnt_o,
  output logic gnt_id_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_id_o = REQ_IF;
    if (req_if_i && req_d_i) begin
      // On a tie, round-robin favours whoever was not granted last.
      gnt_id_o = (ArbMode == 0) ? REQ_D : ~last_q;
    end else if (req_d_i) begin
      gnt_id_o = REQ_D;
    end
    gnt_o  = en_i && (req_if_i || req_d_i);
    last_d = gnt_o ? gnt_id_o : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_IF;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one AXI4-Lite master port between instruction fetch and data load/store,
// running one transaction at a time and pulsing done to the granted requester.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ARB_MODE = 1,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_done,
  output logic [31:0]       rdata,
  output logic              ARvalid,
  input  logic              ARready,
  output logic [ADDR_W-1:0] ARdata,
  input  logic              Rvalid,
  output logic              RReady,
  input  logic [31:0]       Rdata,
  output logic              AWvalid,
  input  logic              AWready,
  output logic [ADDR_W-1:0] AWdata,
  output logic              Wvalid,
  input  logic              Wready,
  output logic [31:0]       Wdata,
  output logic [3:0]        Wstrb,
  input  logic              Bvalid,
  output logic              Bready
);

  state_e            state_q, state_d;
  logic              id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic arb_en, gnt, gnt_id;

  // No arbitration in a done cycle, so a requester still holding req is not re-granted.
  assign arb_en = (state_q == StIdle) && !if_done_q && !d_done_q;

  mem_bus_arbiter_rr_arb2 #(
    .ArbMode(ARB_MODE)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_if_i(if_req),
    .req_d_i (d_req),
    .en_i    (arb_en),
    .gnt_o   (gnt),
    .gnt_id_o(gnt_id)
  );

  assign ARvalid = (state_q == StRdAddr);
  assign ARdata  = addr_q;
  assign RReady  = (state_q == StRdData);
  assign AWvalid = (state_q == StWrReq) && !aw_done_q;
  assign AWdata  = addr_q;
  assign Wvalid  = (state_q == StWrReq) && !w_done_q;
  assign Wdata   = wdata_q;
  assign Wstrb   = wstrb_q;
  assign Bready  = (state_q == StWrResp);
  assign rdata   = rdata_q;
  assign if_done = if_done_q;
  assign d_done  = d_done_q;

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    if_done_d = 1'b0;
    d_done_d  = 1'b0;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    case (state_q)
      StIdle: begin
        if (gnt) begin
          id_d      = gnt_id;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (gnt_id == REQ_D) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            wstrb_d = d_wstrb;
            state_d = d_we ? StWrReq : StRdAddr;
          end else begin
            addr_d  = if_addr;
            state_d = StRdAddr;
          end
        end
      end
      StRdAddr: begin
        if (ARready) state_d = StRdData;
      end
      StRdData: begin
        if (Rvalid) begin
          rdata_d = Rdata;
          state_d = StIdle;
          if (id_q == REQ_D) d_done_d = 1'b1;
          else               if_done_d = 1'b1;
        end
      end
      StWrReq: begin
        // AW and W handshake independently; move on once both have happened.
        if (AWvalid && AWready) aw_done_d = 1'b1;
        if (Wvalid && Wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        if (Bvalid) begin
          d_done_d = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      id_q      <= REQ_IF;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      if_done_q <= if_done_d;
      d_done_q  <= d_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: round-robin instance plus a fixed-priority instance.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, Rdata;
  logic [3:0]  d_wstrb;
  logic        ARready, Rvalid, AWready, Wready, Bvalid;

  logic        if_done, d_done, ARvalid, RReady, AWvalid, Wvalid, Bready;
  logic [31:0] rdata, ARdata, AWdata, Wdata;
  logic [3:0]  Wstrb;

  logic        f_if_done, f_d_done, f_ARvalid, f_RReady, f_AWvalid, f_Wvalid, f_Bready;
  logic [31:0] f_rdata, f_ARdata, f_AWdata, f_Wdata;
  logic [3:0]  f_Wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ARB_MODE(1), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_done(d_done), .rdata(rdata), .ARvalid(ARvalid), .ARready(ARready), .ARdata(ARdata),
    .Rvalid(Rvalid), .RReady(RReady), .Rdata(Rdata), .AWvalid(AWvalid), .AWready(AWready),
    .AWdata(AWdata), .Wvalid(Wvalid), .Wready(Wready), .Wdata(Wdata), .Wstrb(Wstrb),
    .Bvalid(Bvalid), .Bready(Bready)
  );

  mem_bus_arbiter #(.ARB_MODE(0), .ADDR_W(32)) dut_fixed (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_done(f_if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_done(f_d_done), .rdata(f_rdata), .ARvalid(f_ARvalid), .ARready(ARready),
    .ARdata(f_ARdata), .Rvalid(Rvalid), .RReady(f_RReady), .Rdata(Rdata),
    .AWvalid(f_AWvalid), .AWready(AWready), .AWdata(f_AWdata), .Wvalid(f_Wvalid),
    .Wready(Wready), .Wdata(f_Wdata), .Wstrb(f_Wstrb), .Bvalid(Bvalid), .Bready(f_Bready)
  );

  task automatic clear_inputs();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    ARready = 0; Rvalid = 0; Rdata = 0; AWready = 0; Wready = 0; Bvalid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({ARvalid, RReady, AWvalid, Wvalid, Bready, if_done, d_done} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {ARvalid, RReady, AWvalid, Wvalid, Bready, if_done, d_done});
    end
    n_tests++;
    if ({rdata, ARdata, Wdata, Wstrb} !== 100'b0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h ARdata=%h Wdata=%h Wstrb=%h want all 0",
               rdata, ARdata, Wdata, Wstrb);
    end
    rst = 0;
    @(negedge clk);
    n_tests++;
    if ({ARvalid, AWvalid, if_done, d_done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b want 0000", {ARvalid, AWvalid, if_done, d_done});
    end
  endtask

  // Zero-wait fetch; req held on through the done cycle.
  task automatic test_fetch();
    if_req = 1; if_addr = 32'h100; ARready = 1; Rvalid = 0; Rdata = 32'h13;
    @(negedge clk);
    n_tests++;
    if (ARvalid !== 1'b1 || ARdata !== 32'h100) begin
      n_fail++;
      $display("FAIL fetch_ar: ARvalid=%b ARdata=%h want 1 00000100", ARvalid, ARdata);
    end
    Rvalid = 1;
    @(negedge clk);
    n_tests++;
    if (ARvalid !== 1'b0 || RReady !== 1'b1 || if_done !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_r: ARvalid=%b RReady=%b if_done=%b want 0 1 0",
               ARvalid, RReady, if_done);
    end
    ARready = 0;
    @(negedge clk);
    n_tests++;
    if (if_done !== 1'b1 || d_done !== 1'b0 || rdata !== 32'h13 || ARvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_done: if_done=%b d_done=%b rdata=%h ARvalid=%b want 1 0 13 0",
               if_done, d_done, rdata, ARvalid);
    end
    Rvalid = 0;
    @(negedge clk);
    n_tests++;
    if (if_done !== 1'b0 || ARvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_after_done: if_done=%b ARvalid=%b want 0 0", if_done, ARvalid);
    end
  endtask

  // Continues from test_fetch: req still high, so one fresh grant follows the done cycle.
  task automatic test_held_req();
    int dones;
    @(negedge clk);
    n_tests++;
    if (ARvalid !== 1'b1 || ARdata !== 32'h100) begin
      n_fail++;
      $display("FAIL held_regrant: ARvalid=%b ARdata=%h want 1 00000100", ARvalid, ARdata);
    end
    if_req = 0; if_addr = 32'hBAD;
    @(negedge clk);
    n_tests++;
    if (ARvalid !== 1'b1 || ARdata !== 32'h100) begin
      n_fail++;
      $display("FAIL held_ar_stable: ARvalid=%b ARdata=%h want 1 00000100", ARvalid, ARdata);
    end
    ARready = 1; Rvalid = 1; Rdata = 32'h77;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if_done === 1'b1) dones++;
      if (i == 0) ARready = 0;
    end
    Rvalid = 0;
    n_tests++;
    if (dones !== 1 || rdata !== 32'h77) begin
      n_fail++;
      $display("FAIL held_single_done: dones=%0d rdata=%h want 1 00000077", dones, rdata);
    end
  endtask

  task automatic test_store();
    int dones;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    AWready = 0; Wready = 1; Bvalid = 0;
    @(negedge clk);
    n_tests++;
    if (AWvalid !== 1'b1 || Wvalid !== 1'b1 || AWdata !== 32'h2000 ||
        Wdata !== 32'hDEADBEEF || Wstrb !== 4'hF) begin
      n_fail++;
      $display("FAIL store_req: AWv=%b Wv=%b AW=%h W=%h S=%h want 1 1 2000 deadbeef f",
               AWvalid, Wvalid, AWdata, Wdata, Wstrb);
    end
    d_wdata = 32'h0; d_addr = 32'h0;
    @(negedge clk);
    n_tests++;
    if (AWvalid !== 1'b1 || Wvalid !== 1'b0 || AWdata !== 32'h2000) begin
      n_fail++;
      $display("FAIL store_w_drop: AWvalid=%b Wvalid=%b AWdata=%h want 1 0 2000",
               AWvalid, Wvalid, AWdata);
    end
    @(negedge clk);
    n_tests++;
    if (AWvalid !== 1'b1 || Bready !== 1'b0) begin
      n_fail++;
      $display("FAIL store_aw_wait: AWvalid=%b Bready=%b want 1 0", AWvalid, Bready);
    end
    AWready = 1;
    @(negedge clk);
    n_tests++;
    if (AWvalid !== 1'b0 || Wvalid !== 1'b0 || Bready !== 1'b1 || d_done !== 1'b0) begin
      n_fail++;
      $display("FAIL store_resp: AWv=%b Wv=%b Bready=%b d_done=%b want 0 0 1 0",
               AWvalid, Wvalid, Bready, d_done);
    end
    AWready = 0; Wready = 0; Bvalid = 1; d_req = 0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (d_done === 1'b1) dones++;
      if (if_done === 1'b1) dones += 10;
      Bvalid = 0;
    end
    n_tests++;
    if (dones !== 1 || rdata !== 32'h77) begin
      n_fail++;
      $display("FAIL store_done: done_score=%0d rdata=%h want 1 00000077", dones, rdata);
    end
  endtask

  task automatic test_reset_mid_read();
    int dones;
    if_req = 1; if_addr = 32'h300; ARready = 1; Rvalid = 0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (RReady !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_in_rdata: RReady=%b want 1", RReady);
    end
    rst = 1; Rvalid = 1; Rdata = 32'h1234;
    #1;
    n_tests++;
    if ({ARvalid, RReady, AWvalid, Wvalid, Bready, if_done, d_done} !== 7'b0 ||
        rdata !== 32'h0 || ARdata !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_outputs: ctrl=%b rdata=%h ARdata=%h want 0 0 0",
               {ARvalid, RReady, AWvalid, Wvalid, Bready, if_done, d_done}, rdata, ARdata);
    end
    if_req = 0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if_done === 1'b1 || d_done === 1'b1) dones++;
      if (i == 1) begin
        rst = 0; Rvalid = 0;
      end
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL midrst_no_done: dones=%0d want 0", dones);
    end
    if_req = 1; if_addr = 32'h400; ARready = 1; Rdata = 32'hA5;
    @(negedge clk);
    n_tests++;
    if (ARvalid !== 1'b1 || ARdata !== 32'h400) begin
      n_fail++;
      $display("FAIL midrst_fresh_ar: ARvalid=%b ARdata=%h want 1 00000400", ARvalid, ARdata);
    end
    if_req = 0; Rvalid = 1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (if_done !== 1'b1 || rdata !== 32'hA5) begin
      n_fail++;
      $display("FAIL midrst_fresh_done: if_done=%b rdata=%h want 1 000000a5", if_done, rdata);
    end
    Rvalid = 0; ARready = 0;
    @(negedge clk);
  endtask

  task automatic test_stray_response();
    int bad;
    Rvalid = 1; Bvalid = 1; Rdata = 32'hFFFFFFFF;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({if_done, d_done, RReady, Bready, ARvalid, AWvalid} !== 6'b0) bad++;
    end
    n_tests++;
    if (bad !== 0 || rdata !== 32'hA5) begin
      n_fail++;
      $display("FAIL stray_resp: bad_cycles=%0d rdata=%h want 0 000000a5", bad, rdata);
    end
    Rvalid = 0; Bvalid = 0;
  endtask

  task automatic test_contention();
    logic seq_rr[4];
    logic seq_fx[4];
    int   n_rr, n_fx, both;
    do_reset();
    if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h2000;
    ARready = 1; Rvalid = 1; Rdata = 32'h5;
    n_rr = 0; n_fx = 0; both = 0;
    for (int i = 0; i < 40 && (n_rr < 4 || n_fx < 4); i++) begin
      @(negedge clk);
      if (if_done && d_done) both++;
      if (f_if_done && f_d_done) both++;
      if (n_rr < 4 && (if_done || d_done)) begin
        seq_rr[n_rr] = d_done;
        n_rr++;
      end
      if (n_fx < 4 && (f_if_done || f_d_done)) begin
        seq_fx[n_fx] = f_d_done;
        n_fx++;
      end
    end
    clear_inputs();
    n_tests++;
    if (n_rr !== 4 || n_fx !== 4 || both !== 0) begin
      n_fail++;
      $display("FAIL contention_count: rr=%0d fixed=%0d both=%0d want 4 4 0", n_rr, n_fx, both);
    end else begin
      n_tests++;
      if ({seq_rr[0], seq_rr[1], seq_rr[2], seq_rr[3]} !== 4'b1010) begin
        n_fail++;
        $display("FAIL contention_rr: seq(1=D)=%b want 1010",
                 {seq_rr[0], seq_rr[1], seq_rr[2], seq_rr[3]});
      end
      n_tests++;
      if ({seq_fx[0], seq_fx[1], seq_fx[2], seq_fx[3]} !== 4'b1111) begin
        n_fail++;
        $display("FAIL contention_fixed: seq(1=D)=%b want 1111",
                 {seq_fx[0], seq_fx[1], seq_fx[2], seq_fx[3]});
      end
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_fetch();
    test_held_req();
    test_store();
    test_reset_mid_read();
    test_stray_response();
    test_contention();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
